// File: rtl/rgb_entry_ctrl.sv
// Keypad colour-entry sequencer: converts the three-digit buffer to binary, range-checks it
// and commits it to R, G, B in turn. Define RGB_ENTRY_AUTOCOMMIT_EN to commit on a full buffer.
module rgb_entry_ctrl #(
    parameter int unsigned MAX_VAL = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] u,
    input  logic [4:0] d,
    input  logic [4:0] c,
    input  logic       rgb_full,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic       mem_clr_n,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [1:0] chan,
    output logic       ch_load,
    output logic       frame_done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_CONV,
        ST_CHECK,
        ST_COMMIT,
        ST_ERR,
        ST_CLEAR
    } state_t;

    localparam logic [4:0] BLANK   = 5'd16;
    localparam logic [9:0] MAX_ACC = 10'(MAX_VAL);

    state_t     state_q, state_d;
    logic [9:0] acc_q, acc_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;
    logic [7:0] b_q, b_d;
    logic [1:0] chan_q, chan_d;
    logic       err_q, err_d;
    logic       mem_clr_n_q, mem_clr_n_d;
    logic       ch_load_q, ch_load_d;
    logic       frame_done_q, frame_done_d;

    logic       start_req;
    logic       digits_ok;
    logic [9:0] c_val, d_val, u_val;
    logic [9:0] c_x100, d_x10, acc_sum;

    function automatic logic [9:0] digit_val(input logic [4:0] x);
        return (x == BLANK) ? 10'd0 : {5'd0, x};
    endfunction

    function automatic logic digit_ok(input logic [4:0] x);
        return (x < 5'd10) || (x == BLANK);
    endfunction

    // Blank digits count as zero; multiplies are built from shifts and adds.
    always_comb begin
        c_val     = digit_val(c);
        d_val     = digit_val(d);
        u_val     = digit_val(u);
        c_x100    = (c_val << 6) + (c_val << 5) + (c_val << 2);
        d_x10     = (d_val << 3) + (d_val << 1);
        acc_sum   = acc_q + u_val;
        digits_ok = digit_ok(c) && digit_ok(d) && digit_ok(u);
`ifdef RGB_ENTRY_AUTOCOMMIT_EN
        start_req = (key_enter || rgb_full) && (u != BLANK);
`else
        start_req = key_enter && (u != BLANK);
`endif
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        chan_d       = chan_q;
        err_d        = err_q;
        ch_load_d    = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (start_req) begin
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d   = c_x100 + d_x10;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                acc_d   = acc_sum;
                state_d = (!digits_ok || (acc_sum > MAX_ACC)) ? ST_ERR : ST_COMMIT;
            end
            ST_COMMIT: begin
                case (chan_q)
                    2'd0:    r_d = acc_q[7:0];
                    2'd1:    g_d = acc_q[7:0];
                    2'd2:    b_d = acc_q[7:0];
                    default: ;
                endcase
                chan_d       = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
                frame_done_d = (chan_q == 2'd2);
                ch_load_d    = 1'b1;
                err_d        = 1'b0;
                state_d      = ST_CLEAR;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        // Abort wins over everything, including a commit already in flight.
        if (key_clear && (state_q != ST_CLEAR)) begin
            state_d      = ST_CLEAR;
            acc_d        = acc_q;
            r_d          = r_q;
            g_d          = g_q;
            b_d          = b_q;
            chan_d       = chan_q;
            err_d        = 1'b0;
            ch_load_d    = 1'b0;
            frame_done_d = 1'b0;
        end

        mem_clr_n_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_WAIT;
            acc_q        <= 10'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            b_q          <= 8'd0;
            chan_q       <= 2'd0;
            err_q        <= 1'b0;
            mem_clr_n_q  <= 1'b1;
            ch_load_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            chan_q       <= chan_d;
            err_q        <= err_d;
            mem_clr_n_q  <= mem_clr_n_d;
            ch_load_q    <= ch_load_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mem_clr_n  = mem_clr_n_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign chan       = chan_q;
    assign ch_load    = ch_load_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule
